lsu_rvs: RTL
============

Name: lsu_rvs

Overview:
- In-order issue queue for memory instructions, directly upstream of the load/store unit.
- Accepts dispatched load/store ops from rename/dispatch and holds their operands.
- Snoops the CDB to capture pending source values.
- Issues the oldest entry to the LSU over a req/rdy handshake once its required operands are ready.
- Program order is preserved: only the head entry may issue.

Parameters:
- TAG_W, 4, width of physical/ROB result tags broadcast on CDB
- ROB_DEPTH, 16, ROB entries
- ROB_PTR_W, $clog2(ROB_DEPTH), inst_id width
- DEPTH, 8, queue entries (power of two, >=2)
- PTR_W, $clog2(DEPTH), index width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  discard all entries (mispredict recovery)
- disp_valid  in  1  dispatch request
- disp_rdy  out  1  queue can accept dispatch
- disp_opc  in  4  lsu op code; bit3=1 store, 0 load
- disp_tag  in  TAG_W  destination tag
- disp_inst_id  in  ROB_PTR_W  ROB index
- disp_offset  in  12  signed immediate
- disp_src1_rdy  in  1  base operand value valid
- disp_src1_tag  in  TAG_W  base operand producer tag
- disp_src1_val  in  32  base operand value
- disp_src2_rdy / disp_src2_tag / disp_src2_val  in  1/TAG_W/32  store-data operand, same meaning as src1
- cdb_valid  in  1  CDB broadcast valid
- cdb_tag  in  TAG_W  broadcast tag
- cdb_wdata  in  32  broadcast value
- iss_req  out  1  head entry ready to issue
- iss_rdy  in  1  LSU accepts
- iss_opc  out  4  head opc
- iss_tag  out  TAG_W  head tag
- iss_inst_id  out  ROB_PTR_W  head inst_id
- iss_offset  out  12  head offset
- iss_src1  out  32  head base value
- iss_src2  out  32  head store data
- count  out  PTR_W+1  occupied entries

Behaviour:
- Storage: circular buffer, wptr/rptr of PTR_W+1 bits.
  - full = MSBs differ, low bits equal.
  - empty = all bits equal.
  - count = wptr - rptr.
- Reset / flush:
  - rst or flush: wptr=rptr=0 and all valid/rdy flags cleared next cycle.
  - After reset: disp_rdy=1, iss_req=0, count=0, all iss_* data outputs 0.
  - flush has priority over dispatch, issue and CDB capture in the same cycle.
- disp_rdy = ~full (combinational from registered pointers).
  - Dispatch while full is ignored even if issue fires the same cycle.
- Dispatch (disp_valid && disp_rdy): write the entry at wptr, wptr+1.
  - For loads (opc[3]=0), src2 is stored ready regardless of disp_src2_rdy; its value is don't-care but stored as 0.
- Dispatch CDB bypass: if a source has rdy=0 and cdb_valid and cdb_tag==src tag in the same cycle, store rdy=1 with value cdb_wdata.
- CDB capture: every cycle, for every valid entry whose src not ready and tag == cdb_tag with cdb_valid, set rdy and value.
  - Both src1 and src2 of one entry may capture in the same cycle.
- Issue:
  - iss_req = head valid && head src1_rdy && head src2_rdy (combinational from registers).
  - iss_* driven from head entry; all zero when queue empty.
  - Transfer when iss_req && iss_rdy: clear head valid, rptr+1.
  - A CDB broadcast in the transfer cycle does not affect the issued values; iss_src* come from registered entry values only.
  - An entry becomes issuable the cycle after its last operand is captured (1-cycle minimum dispatch-to-issue latency).
- Simultaneous dispatch and issue when not full: both occur; count unchanged.
- Wrap-around: pointers roll over naturally; full/empty stay correct at DEPTH boundaries.
- No reordering: a ready younger entry waits behind a non-ready head.

Test Plan:
- Reset: assert rst 2 cycles -> disp_rdy=1, iss_req=0, count=0.
- Dispatch lw (opc lsu_op_lw), src1_rdy=1, val=0x1000, offset=0x004 -> next cycle iss_req=1, iss_src1=0x1000, iss_offset=0x004.
  - Hold iss_rdy=1 -> count returns 0 the following cycle.
- Dispatch sw with src2_rdy=0, tag=5 -> iss_req=0.
  - CDB tag=5, data=0xDEADBEEF -> next cycle iss_req=1, iss_src2=0xDEADBEEF.
  - Repeat with CDB in the dispatch cycle -> same result via bypass.
- Head blocked: head load waits on tag 3, younger load ready -> iss_req stays 0.
  - After CDB tag 3 -> head issues first, younger entry next.
- Fill 8 entries with iss_rdy=0 -> disp_rdy=0, count=8; extra dispatch dropped.
  - Dispatch + issue in the same cycle while full -> count=7.
  - Drain -> values issue in order across pointer wrap.
- Flush with 5 entries and a coincident dispatch and CDB -> next cycle count=0, iss_req=0, disp_rdy=1.

Source files
------------

// File: rtl/lsu_rvs_if.sv
// lsu_rvs_if: bundle of the memory-op issue queue's dispatch, CDB, issue and
// occupancy signals.
//   master : rename/dispatch + CDB + LSU side (drives dispatch, CDB, iss_rdy,
//            flush; observes disp_rdy, iss_* and count)
//   slave  : the issue queue itself (lsu_rvs)
interface lsu_rvs_if #(
  parameter int TAG_W     = 4,
  parameter int ROB_PTR_W = 4,
  parameter int PTR_W     = 3
);
  logic                 flush;
  // dispatch
  logic                 disp_valid;
  logic                 disp_rdy;
  logic [3:0]           disp_opc;
  logic [TAG_W-1:0]     disp_tag;
  logic [ROB_PTR_W-1:0] disp_inst_id;
  logic [11:0]          disp_offset;
  logic                 disp_src1_rdy;
  logic [TAG_W-1:0]     disp_src1_tag;
  logic [31:0]          disp_src1_val;
  logic                 disp_src2_rdy;
  logic [TAG_W-1:0]     disp_src2_tag;
  logic [31:0]          disp_src2_val;
  // common data bus
  logic                 cdb_valid;
  logic [TAG_W-1:0]     cdb_tag;
  logic [31:0]          cdb_wdata;
  // issue
  logic                 iss_req;
  logic                 iss_rdy;
  logic [3:0]           iss_opc;
  logic [TAG_W-1:0]     iss_tag;
  logic [ROB_PTR_W-1:0] iss_inst_id;
  logic [11:0]          iss_offset;
  logic [31:0]          iss_src1;
  logic [31:0]          iss_src2;
  // occupancy
  logic [PTR_W:0]       count;

  modport master (
    output flush, disp_valid, disp_opc, disp_tag, disp_inst_id, disp_offset,
           disp_src1_rdy, disp_src1_tag, disp_src1_val,
           disp_src2_rdy, disp_src2_tag, disp_src2_val,
           cdb_valid, cdb_tag, cdb_wdata, iss_rdy,
    input  disp_rdy, iss_req, iss_opc, iss_tag, iss_inst_id, iss_offset,
           iss_src1, iss_src2, count
  );

  modport slave (
    input  flush, disp_valid, disp_opc, disp_tag, disp_inst_id, disp_offset,
           disp_src1_rdy, disp_src1_tag, disp_src1_val,
           disp_src2_rdy, disp_src2_tag, disp_src2_val,
           cdb_valid, cdb_tag, cdb_wdata, iss_rdy,
    output disp_rdy, iss_req, iss_opc, iss_tag, iss_inst_id, iss_offset,
           iss_src1, iss_src2, count
  );
endinterface

// File: rtl/lsu_rvs.sv
// lsu_rvs: in-order issue queue for load/store ops in front of the LSU.
// Holds dispatched ops and their operands in a circular buffer, snoops the
// CDB for pending operands and issues only the oldest entry once ready.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - lsu_rvs_if.slave: flush, dispatch (disp_*), CDB (cdb_*),
//          issue handshake (iss_*), occupancy (count)
module lsu_rvs #(
  parameter int TAG_W     = 4,
  parameter int ROB_DEPTH = 16,
  parameter int ROB_PTR_W = $clog2(ROB_DEPTH),
  parameter int DEPTH     = 8,
  parameter int PTR_W     = $clog2(DEPTH)
) (
  input logic     clk,
  input logic     rst,
  lsu_rvs_if.slave bus
);

  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  // pointers carry one extra wrap bit to tell full from empty
  logic [PTR_W:0]       wptr_r, rptr_r;

  logic [DEPTH-1:0]     valid_r;
  logic [DEPTH-1:0]     s1_rdy_r;
  logic [DEPTH-1:0]     s2_rdy_r;
  logic [3:0]           opc_r     [DEPTH];
  logic [TAG_W-1:0]     tag_r     [DEPTH];
  logic [ROB_PTR_W-1:0] inst_id_r [DEPTH];
  logic [11:0]          offset_r  [DEPTH];
  logic [TAG_W-1:0]     s1_tag_r  [DEPTH];
  logic [31:0]          s1_val_r  [DEPTH];
  logic [TAG_W-1:0]     s2_tag_r  [DEPTH];
  logic [31:0]          s2_val_r  [DEPTH];

  logic                 full_s, empty_s;
  logic [PTR_W-1:0]     head_s, wr_idx_s;
  logic                 disp_fire_s, iss_fire_s, iss_req_s;
  logic                 new_s1_rdy_s, new_s2_rdy_s;
  logic [31:0]          new_s1_val_s, new_s2_val_s;

  assign full_s      = (wptr_r[PTR_W] != rptr_r[PTR_W]) &&
                       (wptr_r[PTR_W-1:0] == rptr_r[PTR_W-1:0]);
  assign empty_s     = (wptr_r == rptr_r);
  assign head_s      = rptr_r[PTR_W-1:0];
  assign wr_idx_s    = wptr_r[PTR_W-1:0];
  // full check uses registered pointers, so an issue in the same cycle
  // cannot free a slot for a dispatch
  assign disp_fire_s = bus.disp_valid && !full_s;
  assign iss_req_s   = !empty_s && valid_r[head_s] && s1_rdy_r[head_s] && s2_rdy_r[head_s];
  assign iss_fire_s  = iss_req_s && bus.iss_rdy;

  assign bus.disp_rdy = !full_s;
  assign bus.iss_req  = iss_req_s;
  assign bus.count    = wptr_r - rptr_r;

  // Operand state for the incoming entry, including same-cycle CDB bypass;
  // loads have no store-data operand so src2 is forced ready with value 0.
  always_comb begin
    new_s1_rdy_s = bus.disp_src1_rdy;
    new_s1_val_s = bus.disp_src1_val;
    new_s2_rdy_s = bus.disp_src2_rdy;
    new_s2_val_s = bus.disp_src2_val;
    if (!bus.disp_src1_rdy && bus.cdb_valid && (bus.cdb_tag == bus.disp_src1_tag)) begin
      new_s1_rdy_s = 1'b1;
      new_s1_val_s = bus.cdb_wdata;
    end else begin
      new_s1_rdy_s = bus.disp_src1_rdy;
    end
    if (!bus.disp_opc[3]) begin
      new_s2_rdy_s = 1'b1;
      new_s2_val_s = 32'h0000_0000;
    end else if (!bus.disp_src2_rdy && bus.cdb_valid && (bus.cdb_tag == bus.disp_src2_tag)) begin
      new_s2_rdy_s = 1'b1;
      new_s2_val_s = bus.cdb_wdata;
    end else begin
      new_s2_rdy_s = bus.disp_src2_rdy;
    end
  end

  // Head entry drives the issue port; everything reads zero when empty.
  always_comb begin
    bus.iss_opc     = 4'h0;
    bus.iss_tag     = '0;
    bus.iss_inst_id = '0;
    bus.iss_offset  = 12'h000;
    bus.iss_src1    = 32'h0000_0000;
    bus.iss_src2    = 32'h0000_0000;
    if (!empty_s) begin
      bus.iss_opc     = opc_r[head_s];
      bus.iss_tag     = tag_r[head_s];
      bus.iss_inst_id = inst_id_r[head_s];
      bus.iss_offset  = offset_r[head_s];
      bus.iss_src1    = s1_val_r[head_s];
      bus.iss_src2    = s2_val_r[head_s];
    end else begin
      bus.iss_opc     = 4'h0;
    end
  end

  // Pointers and per-entry valid/ready flags; flush outranks everything else.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      wptr_r   <= '0;
      rptr_r   <= '0;
      valid_r  <= '0;
      s1_rdy_r <= '0;
      s2_rdy_r <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_r[i] && bus.cdb_valid && !s1_rdy_r[i] && (s1_tag_r[i] == bus.cdb_tag)) begin
          s1_rdy_r[i] <= 1'b1;
        end
        if (valid_r[i] && bus.cdb_valid && !s2_rdy_r[i] && (s2_tag_r[i] == bus.cdb_tag)) begin
          s2_rdy_r[i] <= 1'b1;
        end
      end
      // dispatch slot is never valid, so it cannot collide with a capture
      if (disp_fire_s) begin
        valid_r[wr_idx_s]  <= 1'b1;
        s1_rdy_r[wr_idx_s] <= new_s1_rdy_s;
        s2_rdy_r[wr_idx_s] <= new_s2_rdy_s;
        wptr_r             <= wptr_r + PTR_ONE;
      end
      if (iss_fire_s) begin
        valid_r[head_s] <= 1'b0;
        rptr_r          <= rptr_r + PTR_ONE;
      end
    end
  end

  // Entry payload and operand values; flags alone decide liveness, so the
  // payload needs no reset.
  always_ff @(posedge clk) begin
    if (!rst && !bus.flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_r[i] && bus.cdb_valid && !s1_rdy_r[i] && (s1_tag_r[i] == bus.cdb_tag)) begin
          s1_val_r[i] <= bus.cdb_wdata;
        end
        if (valid_r[i] && bus.cdb_valid && !s2_rdy_r[i] && (s2_tag_r[i] == bus.cdb_tag)) begin
          s2_val_r[i] <= bus.cdb_wdata;
        end
      end
      if (disp_fire_s) begin
        opc_r[wr_idx_s]     <= bus.disp_opc;
        tag_r[wr_idx_s]     <= bus.disp_tag;
        inst_id_r[wr_idx_s] <= bus.disp_inst_id;
        offset_r[wr_idx_s]  <= bus.disp_offset;
        s1_tag_r[wr_idx_s]  <= bus.disp_src1_tag;
        s1_val_r[wr_idx_s]  <= new_s1_val_s;
        s2_tag_r[wr_idx_s]  <= bus.disp_src2_tag;
        s2_val_r[wr_idx_s]  <= new_s2_val_s;
      end
    end
  end

endmodule
